ppe_req_tracker_w512: RTL and testbench
=======================================

# ppe_req_tracker_w512

Request-bitmap owner for the 512-entry programmable priority encoder. It sits upstream of the encoder. It collects request arrivals as 9-bit indices and decodes each one into a 512-bit pending bitmap that drives the encoder's `Req` input. Each encoded grant index (plus valid) returned by the encoder retires the matching bit. It also keeps a pending count and sticky protocol-error flags.

## Interface
- `W`, 512, bitmap width / number of requesters
- `IDXW`, 9, index width, log2(W)
- `CNTW`, 10, pending-count width, log2(W)+1
- `clk`  in  1  single clock; all logic rises on posedge
- `rst`  in  1  synchronous, active-high reset
- `set_valid`  in  1  request arrival strobe
- `set_idx`  in  IDXW  index of arriving requester
- `gnt_valid`  in  1  grant strobe from encoder (`valid`)
- `gnt_idx`  in  IDXW  granted index from encoder (`o_value_wire`)
- `err_clr`  in  1  clears both sticky error flags
- `req`  out  W  registered pending bitmap; connects to encoder `Req`
- `pend_cnt`  out  CNTW  number of set bits in `req`, 0..512
- `empty`  out  1  `pend_cnt == 0`, registered
- `full`  out  1  `pend_cnt == 512`, registered
- `err_dup`  out  1  sticky: set arrived for an already-pending index
- `err_spur`  out  1  sticky: grant arrived for a non-pending index

## Operation
- Decode: `set_oh = set_valid ? 1<<set_idx : 0`; `gnt_oh = gnt_valid ? 1<<gnt_idx : 0`.
- Bitmap update: `req_next = (req & ~gnt_oh) | set_oh`. Set has priority over clear on the same bit.
- Error and count rules, all evaluated against the current `req`:
  - Set on pending bit, no grant to the same index: bit stays 1, `err_dup` ← 1, no count change.
  - Grant on non-pending bit: `err_spur` ← 1, no count change from the grant.
  - Set and grant, same index, bit pending: grant retires the old request and set re-arms it. Bit stays 1, count unchanged, no error.
  - Set and grant, same index, bit not pending: bit becomes 1, count +1, `err_spur` ← 1, `err_dup` unchanged.
  - Set and grant, different indices: each is handled independently. Net count delta is −1, 0 or +1.
- Count arithmetic is CNTW-bit unsigned and is updated incrementally (+add −retire), not by popcount.
  - Cannot exceed 512 or go below 0 by construction.
  - The bench checks that `pend_cnt` equals popcount(`req`) every cycle.
- `err_clr` clears both flags. If a new error event occurs in the same cycle, that flag ends at 1.
- No backpressure. `set_valid` and `gnt_valid` are accepted every cycle.

## Timing
- Reset (synchronous, `rst`=1 at posedge):
  - `req`=0, `pend_cnt`=0, `empty`=1, `full`=0, `err_dup`=0, `err_spur`=0.
  - Inputs are ignored in the reset cycle.
  - Reset mid-operation discards all pending bits with no retirement reporting.
- Latency is 1 cycle. A set or grant sampled at edge N is reflected in `req`, `pend_cnt`, `empty`, `full` and the errors after edge N.
- The encoder's registered pipeline returns a grant at least 2 cycles after the bit appears in `req`. The tracker places no constraint on that latency and does not track outstanding grants.
- All outputs come directly from flops; there is no combinational input-to-output path.

## Structure
- Shared package `ppe_pkg`:
  - Constants `PPE_W`=512, `PPE_IDXW`=9, `PPE_CNTW`=10.
  - Shared by the encoder and the tracker.
- Sub-module `decoder_9_to_512`: combinational index→one-hot with an enable. It is the inverse of the encoder's 512→9 encoder. It is instantiated twice, once for set and once for grant.
- The top holds the bitmap flops, the count and flags logic, and the registered `empty`/`full`.

## Test plan
- Reset, then set idx 0, 511 and 300 on consecutive cycles → `req` bits {0,300,511} set, `pend_cnt`=3, `empty`=0. Grant 300 → bit cleared next cycle, `pend_cnt`=2.
- Same-cycle set 42 and grant 42 while 42 is pending → `req[42]`=1, `pend_cnt` unchanged, no errors. Repeat with 42 not pending → `req[42]`=1, count +1, `err_spur`=1.
- Set 7 twice (7 already pending) → `err_dup`=1, `pend_cnt` unchanged. `err_clr` → `err_dup`=0. `err_clr` in the same cycle as a grant to non-pending 8 → `err_spur`=1.
- Set all 512 indices → `full`=1, `pend_cnt`=512. Grant each index in ascending order → `empty`=1 after the final grant, and no errors throughout.
- Closed loop with the encoder, 200 random set cycles → every index granted exactly once. `pend_cnt` equals popcount(`req`) every cycle. `err_dup` and `err_spur` stay 0.
- Assert `rst` mid-stream with 100 pending → next cycle `req`=0 and `pend_cnt`=0. `set_valid` in the reset cycle is ignored.

Source files
------------

// File: rtl/ppe_pkg.sv
// Constants shared by the 512-entry programmable priority encoder and its
// request tracker.
package ppe_pkg;
    localparam int PPE_W    = 512;
    localparam int PPE_IDXW = 9;
    localparam int PPE_CNTW = 10;
endpackage

// File: rtl/ppe_req_tracker_w512_decoder.sv
// Combinational index-to-one-hot decoder with enable; the inverse of the
// encoder's 512-to-9 stage.
module decoder_9_to_512
    import ppe_pkg::*;
#(
    parameter int W    = PPE_W,
    parameter int IDXW = PPE_IDXW
) (
    input  logic            en,
    input  logic [IDXW-1:0] idx,
    output logic [W-1:0]    oh
);

    always_comb begin
        oh = '0;
        if (en) begin
            oh[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/ppe_req_tracker_w512.sv
// Pending-request bitmap feeding the priority encoder: arrivals set bits,
// returned grants retire them, with an incremental count and sticky errors.
module ppe_req_tracker_w512
    import ppe_pkg::*;
#(
    parameter int W    = PPE_W,
    parameter int IDXW = PPE_IDXW,
    parameter int CNTW = PPE_CNTW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_valid,
    input  logic [IDXW-1:0] set_idx,
    input  logic            gnt_valid,
    input  logic [IDXW-1:0] gnt_idx,
    input  logic            err_clr,
    output logic [W-1:0]    req,
    output logic [CNTW-1:0] pend_cnt,
    output logic            empty,
    output logic            full,
    output logic            err_dup,
    output logic            err_spur
);

    logic [W-1:0]    set_oh;
    logic [W-1:0]    gnt_oh;
    logic [W-1:0]    req_next;
    logic [CNTW-1:0] cnt_next;
    logic            set_hit;
    logic            gnt_hit;
    logic            same_idx;
    logic            add;
    logic            retire;
    logic            dup_evt;
    logic            spur_evt;

    decoder_9_to_512 #(.W(W), .IDXW(IDXW)) u_set_dec (
        .en  (set_valid),
        .idx (set_idx),
        .oh  (set_oh)
    );

    decoder_9_to_512 #(.W(W), .IDXW(IDXW)) u_gnt_dec (
        .en  (gnt_valid),
        .idx (gnt_idx),
        .oh  (gnt_oh)
    );

    // A grant and a set on the same pending bit cancel: retire old, re-arm new.
    always_comb begin
        set_hit  = |(req & set_oh);
        gnt_hit  = |(req & gnt_oh);
        same_idx = |(set_oh & gnt_oh);
        add      = set_valid & ~set_hit;
        retire   = gnt_hit & ~same_idx;
        dup_evt  = set_hit & ~same_idx;
        spur_evt = gnt_valid & ~gnt_hit;
        req_next = (req & ~gnt_oh) | set_oh;
        cnt_next = pend_cnt + {{(CNTW-1){1'b0}}, add} - {{(CNTW-1){1'b0}}, retire};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req      <= '0;
            pend_cnt <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            err_dup  <= 1'b0;
            err_spur <= 1'b0;
        end else begin
            req      <= req_next;
            pend_cnt <= cnt_next;
            empty    <= (cnt_next == '0);
            full     <= (cnt_next == CNTW'(W));
            err_dup  <= (err_dup & ~err_clr) | dup_evt;
            err_spur <= (err_spur & ~err_clr) | spur_evt;
        end
    end

endmodule

// File: tb/tb_ppe_req_tracker_w512.sv
// Self-checking bench for ppe_req_tracker_w512: directed scenarios plus a
// randomized closed loop, all compared against a set-based reference model.
module tb_ppe_req_tracker_w512;

    logic         clk = 1'b0;
    logic         rst;
    logic         set_valid;
    logic [8:0]   set_idx;
    logic         gnt_valid;
    logic [8:0]   gnt_idx;
    logic         err_clr;
    logic [511:0] req;
    logic [9:0]   pend_cnt;
    logic         empty;
    logic         full;
    logic         err_dup;
    logic         err_spur;

    int checks   = 0;
    int failures = 0;

    // Reference model: the set of pending indices plus the two sticky flags.
    bit        pending[512];
    bit        mdup;
    bit        mspur;
    int        setCnt[512];
    int        gntCnt[512];

    ppe_req_tracker_w512 dut (
        .clk       (clk),
        .rst       (rst),
        .set_valid (set_valid),
        .set_idx   (set_idx),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .err_clr   (err_clr),
        .req       (req),
        .pend_cnt  (pend_cnt),
        .empty     (empty),
        .full      (full),
        .err_dup   (err_dup),
        .err_spur  (err_spur)
    );

    always #5 clk = ~clk;

    function automatic int modelCount();
        int n = 0;
        for (int i = 0; i < 512; i++) n += pending[i] ? 1 : 0;
        return n;
    endfunction

    function automatic logic [511:0] modelVec();
        logic [511:0] v = '0;
        for (int i = 0; i < 512; i++) v[i] = pending[i];
        return v;
    endfunction

    task automatic compare(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply one cycle of the rules to the model, using the inputs the DUT just sampled.
    task automatic modelStep();
        bit wasPending;
        bit gntPending;
        bit same;
        if (rst) begin
            for (int i = 0; i < 512; i++) pending[i] = 1'b0;
            mdup  = 1'b0;
            mspur = 1'b0;
        end else begin
            wasPending = set_valid && pending[set_idx];
            gntPending = gnt_valid && pending[gnt_idx];
            same       = set_valid && gnt_valid && (set_idx == gnt_idx);
            if (err_clr) begin
                mdup  = 1'b0;
                mspur = 1'b0;
            end
            if (gnt_valid) begin
                if (!gntPending) mspur = 1'b1;
                pending[gnt_idx] = 1'b0;
            end
            if (set_valid) begin
                if (wasPending && !same) mdup = 1'b1;
                pending[set_idx] = 1'b1;
            end
        end
    endtask

    task automatic checkOutput();
        int n;
        n = modelCount();
        compare("req", req, modelVec());
        compare("pend_cnt", 512'(pend_cnt), 512'(n));
        compare("cnt_popcount", 512'(pend_cnt), 512'($countones(req)));
        compare("empty", 512'(empty), 512'(n == 0));
        compare("full", 512'(full), 512'(n == 512));
        compare("err_dup", 512'(err_dup), 512'(mdup));
        compare("err_spur", 512'(err_spur), 512'(mspur));
    endtask

    task automatic applyStimulus(input logic r, input logic sv, input int si,
                                 input logic gv, input int gi, input logic ec);
        rst       = r;
        set_valid = sv;
        set_idx   = 9'(si);
        gnt_valid = gv;
        gnt_idx   = 9'(gi);
        err_clr   = ec;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        int q[$];
        int born[$];
        int cyc;
        int si;
        int gi;
        logic sv;
        logic gv;
        int bad;
        logic [511:0] lit;

        for (int i = 0; i < 512; i++) pending[i] = 1'b0;
        mdup = 1'b0;
        mspur = 1'b0;

        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        applyStimulus(1'b1, 1'b1, 5, 1'b1, 6, 1'b0);
        compare("lit_rst_empty", 512'(empty), 512'(1));
        compare("lit_rst_cnt", 512'(pend_cnt), 512'(0));

        // Basic sets and a grant.
        applyStimulus(1'b0, 1'b1, 0, 1'b0, 0, 1'b0);
        applyStimulus(1'b0, 1'b1, 511, 1'b0, 0, 1'b0);
        applyStimulus(1'b0, 1'b1, 300, 1'b0, 0, 1'b0);
        lit = '0;
        lit[0] = 1'b1;
        lit[300] = 1'b1;
        lit[511] = 1'b1;
        compare("lit_req3", req, lit);
        compare("lit_cnt3", 512'(pend_cnt), 512'(3));
        compare("lit_notempty", 512'(empty), 512'(0));
        applyStimulus(1'b0, 1'b0, 0, 1'b1, 300, 1'b0);
        compare("lit_cnt2", 512'(pend_cnt), 512'(2));
        compare("lit_bit300", 512'(req[300]), 512'(0));

        // Same-index set+grant, pending and not pending.
        applyStimulus(1'b0, 1'b1, 42, 1'b0, 0, 1'b0);
        applyStimulus(1'b0, 1'b1, 42, 1'b1, 42, 1'b0);
        compare("lit_rearm_cnt", 512'(pend_cnt), 512'(3));
        compare("lit_rearm_err", 512'({err_dup, err_spur}), 512'(0));
        applyStimulus(1'b0, 1'b0, 0, 1'b1, 42, 1'b0);
        applyStimulus(1'b0, 1'b1, 42, 1'b1, 42, 1'b0);
        compare("lit_spur_same_cnt", 512'(pend_cnt), 512'(3));
        compare("lit_spur_same", 512'(err_spur), 512'(1));
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 0, 1'b1);

        // Duplicate set, clear, and clear racing a new spurious grant.
        applyStimulus(1'b0, 1'b1, 7, 1'b0, 0, 1'b0);
        applyStimulus(1'b0, 1'b1, 7, 1'b0, 0, 1'b0);
        compare("lit_dup", 512'(err_dup), 512'(1));
        compare("lit_dup_cnt", 512'(pend_cnt), 512'(4));
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
        compare("lit_dup_clr", 512'(err_dup), 512'(0));
        applyStimulus(1'b0, 1'b0, 0, 1'b1, 8, 1'b1);
        compare("lit_clr_spur", 512'(err_spur), 512'(1));
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 0, 1'b1);

        // Fill every index, then drain ascending.
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 512; i++) applyStimulus(1'b0, 1'b1, i, 1'b0, 0, 1'b0);
        compare("lit_full", 512'(full), 512'(1));
        compare("lit_full_cnt", 512'(pend_cnt), 512'(512));
        for (int i = 0; i < 512; i++) applyStimulus(1'b0, 1'b0, 0, 1'b1, i, 1'b0);
        compare("lit_drained", 512'(empty), 512'(1));
        compare("lit_drain_err", 512'({err_dup, err_spur}), 512'(0));

        // Randomized closed loop: grants return at least two cycles after the set.
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 512; i++) begin
            setCnt[i] = 0;
            gntCnt[i] = 0;
        end
        cyc = 0;
        while (cyc < 200 || q.size() > 0) begin
            sv = (cyc < 200) && ($urandom_range(0, 3) != 0);
            si = 0;
            if (sv) begin
                do si = $urandom_range(0, 511); while (pending[si]);
                q.push_back(si);
                born.push_back(cyc);
                setCnt[si]++;
            end
            gv = 1'b0;
            gi = 0;
            if (q.size() > 0 && (cyc - born[0]) >= 2 && ($urandom_range(0, 2) != 0 || cyc >= 200)) begin
                gv = 1'b1;
                gi = q.pop_front();
                void'(born.pop_front());
                gntCnt[gi]++;
            end
            applyStimulus(1'b0, sv, si, gv, gi, 1'b0);
            cyc++;
        end
        bad = 0;
        for (int i = 0; i < 512; i++) if (gntCnt[i] != setCnt[i]) bad++;
        compare("loop_grant_once", 512'(bad), 512'(0));
        compare("loop_err", 512'({err_dup, err_spur}), 512'(0));

        // Reset mid-stream with 100 pending; the set during reset is dropped.
        for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b1, i * 5, 1'b0, 0, 1'b0);
        compare("lit_pend100", 512'(pend_cnt), 512'(100));
        applyStimulus(1'b1, 1'b1, 3, 1'b0, 0, 1'b0);
        compare("lit_midrst_req", req, 512'(0));
        compare("lit_midrst_cnt", 512'(pend_cnt), 512'(0));
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
